// File: rtl/flash_stream_reader.sv
// -----------------------------------------------------------------------------
// flash_stream_reader
//
// Streams a word range out of an Avalon-MM flash slave into a small prefetch
// FIFO and hands words to a consumer one at a time on request. The range can
// be walked ascending or descending, once or looping forever.
//
// Ports
//   sample_clk, reset          clock, synchronous active-high reset
//   start / stop               one-cycle control pulses
//   loop_en, reverse           mode bits, latched at start
//   start_addr, end_addr       inclusive word range, latched at start
//   flash_mem_*                Avalon-MM read master (pipelined, waitrequest)
//   sample_req                 consumer pulse: pop one word
//   flash_data                 last word popped
//   valid_read_flag            flash_data updated this cycle
//   underrun                   sample_req found the FIFO empty
//   busy / done                status (busy in RUN, DRAIN, FLUSH; done in DONE)
// -----------------------------------------------------------------------------
module flash_stream_reader #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              sample_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              reverse,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    input  logic              sample_req,
    output logic [DATA_W-1:0] flash_data,
    output logic              valid_read_flag,
    output logic              underrun,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // latched transfer configuration
    logic              loop_q;
    logic              rev_q;
    logic [ADDR_W-1:0] lo_q;
    logic [ADDR_W-1:0] hi_q;

    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic [CNT_W:0]    inflight;
    logic              accept;
    logic              push;
    logic              pop;
    logic              rsp_dec;
    logic              at_last;
    logic              fifo_clr;
    logic              load_cfg;

    // Words already in the FIFO plus words still owed by the slave never
    // exceed the FIFO depth, so every response always has a slot waiting.
    assign inflight          = {1'b0, outstanding} + {1'b0, fifo_count};
    assign flash_mem_read    = (state_q == S_RUN) && (inflight < DEPTH_C);
    assign flash_mem_address = cur_addr;
    assign accept            = flash_mem_read && !flash_mem_waitrequest;
    assign at_last           = (cur_addr == (rev_q ? lo_q : hi_q));

    // Responses are only kept in RUN/DRAIN; FLUSH still counts them down so
    // it knows when the slave has gone quiet. IDLE/DONE ignore them entirely.
    assign push    = flash_mem_readdatavalid && (state_q == S_RUN || state_q == S_DRAIN);
    assign rsp_dec = flash_mem_readdatavalid && (outstanding != '0) &&
                     (state_q == S_RUN || state_q == S_DRAIN || state_q == S_FLUSH);
    assign pop     = sample_req && (fifo_count != '0);

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
    assign done = (state_q == S_DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge sample_clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_clr = 1'b0;
        load_cfg = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    load_cfg = 1'b1;
                    fifo_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d  = S_FLUSH;
                    fifo_clr = 1'b1;
                end else if (accept && at_last && !loop_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    state_d  = S_FLUSH;
                    fifo_clr = 1'b1;
                end else if (outstanding == '0 && fifo_count == '0) begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                if (outstanding == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ address / config
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            loop_q   <= 1'b0;
            rev_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            cur_addr <= '0;
        end else if (load_cfg) begin
            loop_q   <= loop_en;
            rev_q    <= reverse;
            lo_q     <= start_addr;
            hi_q     <= end_addr;
            cur_addr <= reverse ? end_addr : start_addr;
        end else if (accept) begin
            if (at_last) begin
                // without looping the address just parks; DRAIN issues nothing
                if (loop_q) cur_addr <= rev_q ? hi_q : lo_q;
            end else begin
                cur_addr <= rev_q ? cur_addr - 1'b1 : cur_addr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ outstanding reads
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, rsp_dec})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ------------------------------------------------------ prefetch FIFO
    always_ff @(posedge sample_clk) begin
        if (push) mem[wr_ptr] <= flash_mem_readdata;
    end

    always_ff @(posedge sample_clk) begin
        if (reset || fifo_clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge sample_clk) begin
        if (!reset) assert (!(push && !pop && fifo_count == FULL_C));
    end

    // ------------------------------------------------------ consumer side
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            flash_data      <= '0;
            valid_read_flag <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            if (pop) flash_data <= mem[rd_ptr];
            valid_read_flag <= pop;
            underrun        <= sample_req && !pop;
        end
    end

endmodule

// File: doc/flash_stream_reader.md
FLASH_STREAM_READER -- requirements
Module: flash_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 23, flash word-address width.
REQ-002 Parameter DATA_W, default 32, flash word width.
REQ-003 Parameter FIFO_DEPTH, default 8, prefetch FIFO depth in words; power of two, minimum 2.
REQ-004 sample_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begin streaming.
REQ-007 stop  in  1  one-cycle pulse; abort streaming.
REQ-008 loop_en  in  1  1 = wrap at range end; sampled at start.
REQ-009 reverse  in  1  1 = descending addresses; sampled at start.
REQ-010 start_addr, end_addr  in  ADDR_W each  inclusive word range; sampled at start; start_addr <= end_addr.
REQ-011 flash_mem_read  out  1  Avalon-MM read request.
REQ-012 flash_mem_address  out  ADDR_W  Avalon-MM word address.
REQ-013 flash_mem_waitrequest  in  1  slave stall.
REQ-014 flash_mem_readdatavalid  in  1  read response strobe.
REQ-015 flash_mem_readdata  in  DATA_W  read response data.
REQ-016 sample_req  in  1  one-cycle pulse; consumer requests one word.
REQ-017 flash_data  out  DATA_W  last word delivered to the consumer.
REQ-018 valid_read_flag  out  1  one-cycle pulse; flash_data updated this cycle.
REQ-019 underrun  out  1  one-cycle pulse; sample_req arrived while the FIFO was empty.
REQ-020 busy  out  1  high in every state except IDLE and DONE.
REQ-021 done  out  1  high in DONE.

Function
REQ-022 FSM states: IDLE, RUN, DRAIN, FLUSH, DONE.
REQ-023 IDLE/DONE + start -> RUN: latch range/modes; cur_addr = start_addr (forward) or end_addr (reverse); FIFO empty.
REQ-024 start is ignored in RUN, DRAIN and FLUSH; stop is ignored in IDLE and DONE.
REQ-025 RUN issue rule: flash_mem_read = 1 iff outstanding + fifo_count < FIFO_DEPTH; both terms are registered values.
REQ-026 While flash_mem_read = 1 and waitrequest = 1: flash_mem_read and flash_mem_address are held stable.
REQ-027 Acceptance = read & ~waitrequest: outstanding +1; address steps +1 (forward) or -1 (reverse).
REQ-028 Range end = end_addr (forward) or start_addr (reverse), accepted: loop_en=1 -> wrap to the range start for that direction, stay in RUN; loop_en=0 -> DRAIN.
REQ-029 readdatavalid in RUN/DRAIN: push readdata into the FIFO; outstanding -1.
REQ-030 Acceptance and readdatavalid in the same cycle leave outstanding unchanged.
REQ-031 Push and pop in the same cycle leave fifo_count unchanged.
REQ-032 A pop on an empty FIFO is not performed, even when a push occurs in the same cycle.
REQ-033 The FIFO never overflows: guaranteed by REQ-025; an overflow is an assertion failure.
REQ-034 sample_req with fifo_count > 0: pop; flash_data = head word and valid_read_flag = 1 on the next cycle.
REQ-035 sample_req with fifo_count = 0: underrun = 1 on the next cycle; flash_data held.
REQ-036 DRAIN: no new reads; pops continue; go to DONE when outstanding = 0 and fifo_count = 0.
REQ-037 Single-word range (start_addr = end_addr) with loop_en = 0: exactly one read, then DRAIN.
REQ-038 stop in RUN/DRAIN -> FLUSH: flash_mem_read = 0 at the next edge.
REQ-039 stop with flash_mem_read = 1 and waitrequest = 1 in the same cycle: the request is withdrawn.
REQ-040 FLUSH: discard returning responses; FIFO cleared; sample_req gives underrun; outstanding = 0 -> IDLE.
REQ-041 readdatavalid in IDLE or DONE is discarded; no counter changes.
REQ-042 Latency: start at cycle N -> flash_mem_read = 1 at N+1.
REQ-043 Latency: readdatavalid at cycle M -> word poppable by sample_req at M+1 -> flash_data at M+2.
REQ-044 outstanding and fifo_count widths: $clog2(FIFO_DEPTH)+1 bits; no wrap.
REQ-045 FIFO pointers: $clog2(FIFO_DEPTH) bits; natural wrap.

Reset
REQ-046 reset dominates all inputs.
REQ-047 Reset values: state = IDLE, flash_mem_read = 0, flash_mem_address = 0, flash_data = 0, valid_read_flag = 0, underrun = 0, busy = 0, done = 0, outstanding = 0, FIFO empty.
REQ-048 Reset mid-transfer: abandon all in-flight reads; later responses are discarded per REQ-041.

Verification
REQ-049 Forward: start_addr=0x10, end_addr=0x13, loop_en=0, zero-wait slave, latency 2 -> addresses 0x10..0x13 each once; 4 sample_req -> 4 words in order; done=1.
REQ-050 Reverse loop: start_addr=0x20, end_addr=0x22, reverse=1, loop_en=1 -> address sequence 0x22,0x21,0x20,0x22,...; no gaps.
REQ-051 Backpressure: FIFO_DEPTH=4, no sample_req -> exactly 4 reads accepted, then flash_mem_read = 0; one sample_req -> one further read.
REQ-052 waitrequest held high 5 cycles -> address and read stable for all 5 cycles; exactly one acceptance.
REQ-053 Underrun: sample_req right after start, before any response -> underrun pulse; flash_data = 0; valid_read_flag = 0.
REQ-054 Stop and reset: stop with 3 reads outstanding -> 3 responses discarded; IDLE after the last; then reset during RUN -> all outputs at reset values next cycle.
